// File: rtl/dmem_port_ctrl_if.sv
// Request/response handshake and byte-lane memory bus for dmem_port_ctrl.
// slave = controller side, master = requester plus lane memories.
interface dmem_port_ctrl_if #(
   parameter int ADDR_WIDTH = 13
);
   logic                  REQ_VALID;
   logic                  REQ_READY;
   logic                  REQ_WE;
   logic [1:0]            REQ_SIZE;
   logic                  REQ_UNSIGNED;
   logic [ADDR_WIDTH-1:0] REQ_ADDR;
   logic [31:0]           REQ_WDATA;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [31:0]           RSP_RDATA;
   logic                  RSP_ERR;
   logic [ADDR_WIDTH-1:0] MEM_W_ADDR;
   logic [ADDR_WIDTH-1:0] MEM_R_ADDR;
   logic [3:0]            MEM_WRITE_EN;
   logic [3:0]            MEM_READ_EN;
   logic [31:0]           MEM_DIN;
   logic [31:0]           MEM_DOUT;

   modport slave (
      input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
      input  RSP_READY, MEM_DOUT,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      output MEM_W_ADDR, MEM_R_ADDR, MEM_WRITE_EN, MEM_READ_EN, MEM_DIN
   );

   modport master (
      output REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA,
      output RSP_READY, MEM_DOUT,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      input  MEM_W_ADDR, MEM_R_ADDR, MEM_WRITE_EN, MEM_READ_EN, MEM_DIN
   );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: one load/store per 3 cycles over four byte lanes.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module dmem_port_ctrl #(
   parameter int ADDR_WIDTH = 13
) (
   input  logic            CLK,
   input  logic            RST_N,
   dmem_port_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_ready_en;
   logic                  r_we;
   logic                  r_uns;
   logic [1:0]            r_size;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_rdata;
   logic                  w_accept;
   logic                  w_mis;
   logic [ADDR_WIDTH-1:0] w_req_addr;
   logic [3:0]            w_lanes;
   logic [31:0]           w_din;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_load;

   assign w_accept = bus.REQ_VALID && r_ready_en && (r_state == S_IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
   logic r_mis;
   logic r_err;
   logic w_req_mis;

   assign w_req_addr = bus.REQ_ADDR;
   assign w_req_mis  = ((bus.REQ_SIZE == 2'b01) && bus.REQ_ADDR[0]) ||
                       (bus.REQ_SIZE[1] && (bus.REQ_ADDR[1:0] != 2'b00));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mis <= 1'b0;
         r_err <= 1'b0;
      end else begin
         if (w_accept)             r_mis <= w_req_mis;
         if (r_state == S_ACCESS)  r_err <= r_mis;
      end
   end

   assign w_mis       = r_mis;
   assign bus.RSP_ERR = r_err;
`else
   always_comb begin
      w_req_addr = bus.REQ_ADDR;
      if (bus.REQ_SIZE == 2'b01) w_req_addr[0]   = 1'b0;
      else if (bus.REQ_SIZE[1])  w_req_addr[1:0] = 2'b00;
   end

   assign w_mis       = 1'b0;
   assign bus.RSP_ERR = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept)      w_next = S_ACCESS;
         S_ACCESS:                    w_next = S_RESP;
         S_RESP:   if (bus.RSP_READY) w_next = S_IDLE;
         default:                     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_ready_en <= 1'b0;
         r_we       <= 1'b0;
         r_uns      <= 1'b0;
         r_size     <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            r_we    <= bus.REQ_WE;
            r_uns   <= bus.REQ_UNSIGNED;
            r_size  <= bus.REQ_SIZE;
            r_addr  <= w_req_addr;
            r_wdata <= bus.REQ_WDATA;
         end
         if (r_state == S_ACCESS) r_rdata <= w_load;
      end
   end

   always_comb begin
      w_lanes = 4'hF;
      w_din   = r_wdata;
      case (r_size)
         2'b00: begin
            w_lanes = 4'b0001 << r_addr[1:0];
            w_din   = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
            w_din   = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane data arrives on the falling edge of ACCESS and is extracted here.
   assign w_byte = bus.MEM_DOUT[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = bus.MEM_DOUT[{r_addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load = '0;
      if (!r_we && !w_mis) begin
         case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = bus.MEM_DOUT;
         endcase
      end
   end

   always_comb begin
      bus.REQ_READY    = r_ready_en && (r_state == S_IDLE);
      bus.RSP_VALID    = (r_state == S_RESP);
      bus.RSP_RDATA    = r_rdata;
      bus.MEM_W_ADDR   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      bus.MEM_R_ADDR   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      bus.MEM_DIN      = w_din;
      bus.MEM_WRITE_EN = 4'h0;
      bus.MEM_READ_EN  = 4'h0;
      if ((r_state == S_ACCESS) && !w_mis) begin
         if (r_we) bus.MEM_WRITE_EN = w_lanes;
         else      bus.MEM_READ_EN  = w_lanes;
      end
   end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a byte-lane memory model and a response scoreboard.
// Misaligned-access expectations follow DMEM_MISALIGN_TRAP_EN.
module tb_dmem_port_ctrl;
   localparam int AW = 13;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   dmem_port_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
   dmem_port_ctrl #(.ADDR_WIDTH(AW)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0] mem [0:2047] = '{default: '0};
   logic [31:0] dout_q       = '0;
   int          en_pulses    = 0;
   logic        both_seen    = 1'b0;
   int          tests        = 0;
   int          fails        = 0;
   rsp_t        sb[$];
   logic [31:0] acc_din;

   assign bus.MEM_DOUT = dout_q;

   // Lane memories: writes and read-data updates happen on the falling edge.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bus.MEM_WRITE_EN[k]) mem[bus.MEM_W_ADDR[AW-1:2]][8*k +: 8] = bus.MEM_DIN[8*k +: 8];
         if (bus.MEM_READ_EN[k])  dout_q[8*k +: 8] = mem[bus.MEM_R_ADDR[AW-1:2]][8*k +: 8];
      end
      if ((|bus.MEM_WRITE_EN) || (|bus.MEM_READ_EN)) en_pulses++;
      if ((|bus.MEM_WRITE_EN) && (|bus.MEM_READ_EN)) both_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [3:0] exp_we, input logic [3:0] exp_re,
                            input logic [31:0] exp_rdata, input logic exp_err, input int hold);
      int          n;
      int          pulses0;
      rsp_t        exp;
      logic [31:0] held;
      n = 0;
      while (bus.REQ_READY !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      if (n == 8) check({tag, "_ready_timeout"}, 32'(bus.REQ_READY), 32'd1);
      bus.REQ_VALID    = 1'b1;
      bus.REQ_WE       = we;
      bus.REQ_SIZE     = size;
      bus.REQ_UNSIGNED = uns;
      bus.REQ_ADDR     = addr;
      bus.REQ_WDATA    = wdata;
      sb.push_back('{exp_rdata, exp_err});
      pulses0 = en_pulses;
      tick();
      // Scramble request fields: the controller must work from its registered copy.
      bus.REQ_VALID    = 1'b0;
      bus.REQ_WE       = ~we;
      bus.REQ_SIZE     = 2'($urandom);
      bus.REQ_UNSIGNED = ~uns;
      bus.REQ_ADDR     = AW'($urandom);
      bus.REQ_WDATA    = $urandom;
      check({tag, "_we"}, 32'(bus.MEM_WRITE_EN), 32'(exp_we));
      check({tag, "_re"}, 32'(bus.MEM_READ_EN), 32'(exp_re));
      check({tag, "_waddr"}, 32'(bus.MEM_W_ADDR), 32'({addr[AW-1:2], 2'b00}));
      check({tag, "_raddr"}, 32'(bus.MEM_R_ADDR), 32'({addr[AW-1:2], 2'b00}));
      check({tag, "_ready_busy"}, 32'(bus.REQ_READY), 32'd0);
      acc_din = bus.MEM_DIN;
      tick();
      check({tag, "_rsp_latency"}, 32'(bus.RSP_VALID), 32'd1);
      held = bus.RSP_RDATA;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, 32'(bus.RSP_VALID), 32'd1);
         check({tag, "_hold_rdata"}, bus.RSP_RDATA, held);
         check({tag, "_hold_ready"}, 32'(bus.REQ_READY), 32'd0);
      end
      bus.RSP_READY = 1'b1;
      exp = sb.pop_front();
      check({tag, "_rdata"}, bus.RSP_RDATA, exp.rdata);
      check({tag, "_err"}, 32'(bus.RSP_ERR), 32'(exp.err));
      tick();
      bus.RSP_READY = 1'b0;
      check({tag, "_rsp_done"}, 32'(bus.RSP_VALID), 32'd0);
      check({tag, "_en_cycles"}, 32'(en_pulses - pulses0), ((exp_we | exp_re) != 4'h0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      bus.REQ_VALID    = 1'b0;
      bus.REQ_WE       = 1'b0;
      bus.REQ_SIZE     = 2'b00;
      bus.REQ_UNSIGNED = 1'b0;
      bus.REQ_ADDR     = '0;
      bus.REQ_WDATA    = '0;
      bus.RSP_READY    = 1'b0;

      #2;
      check("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
      check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("rst_rsp_rdata", bus.RSP_RDATA, 32'd0);
      check("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
      check("rst_we", 32'(bus.MEM_WRITE_EN), 32'd0);
      check("rst_re", 32'(bus.MEM_READ_EN), 32'd0);
      check("rst_waddr", 32'(bus.MEM_W_ADDR), 32'd0);
      check("rst_raddr", 32'(bus.MEM_R_ADDR), 32'd0);
      check("rst_din", bus.MEM_DIN, 32'd0);
      tick();
      check("rst_held_ready", 32'(bus.REQ_READY), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      check("ready_after_rst", 32'(bus.REQ_READY), 32'd1);

      do_access("st_word", 1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0, 1'b0, 0);
      check("st_word_din", acc_din, 32'hDEADBEEF);
      do_access("ld_word", 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

      do_access("st_w80", 1'b1, 2'b10, 1'b0, 13'h010, 32'h80000000, 4'hF, 4'h0, 32'h0, 1'b0, 0);
      do_access("ld_b_s", 1'b0, 2'b00, 1'b0, 13'h013, 32'h0, 4'h0, 4'h8, 32'hFFFFFF80, 1'b0, 0);
      do_access("ld_b_u", 1'b0, 2'b00, 1'b1, 13'h013, 32'h0, 4'h0, 4'h8, 32'h00000080, 1'b0, 0);

      do_access("st_half", 1'b1, 2'b01, 1'b0, 13'h022, 32'hFFFF1234, 4'hC, 4'h0, 32'h0, 1'b0, 0);
      check("st_half_din_hi", 32'(acc_din[31:16]), 32'h1234);
      do_access("st_h8001", 1'b1, 2'b01, 1'b0, 13'h020, 32'h00008001, 4'h3, 4'h0, 32'h0, 1'b0, 0);
      do_access("ld_h_s", 1'b0, 2'b01, 1'b0, 13'h020, 32'h0, 4'h0, 4'h3, 32'hFFFF8001, 1'b0, 0);
      do_access("ld_h_u", 1'b0, 2'b01, 1'b1, 13'h020, 32'h0, 4'h0, 4'h3, 32'h00008001, 1'b0, 0);
      do_access("st_byte", 1'b1, 2'b00, 1'b0, 13'h021, 32'h123456A5, 4'h2, 4'h0, 32'h0, 1'b0, 0);
      check("st_byte_din", acc_din, 32'hA5A5A5A5);
      do_access("ld_w020", 1'b0, 2'b10, 1'b0, 13'h020, 32'h0, 4'h0, 4'hF, 32'h1234A501, 1'b0, 0);
      do_access("ld_b_hi", 1'b0, 2'b00, 1'b0, 13'h022, 32'h0, 4'h0, 4'h4, 32'h00000034, 1'b0, 0);

      do_access("hold", 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 4'h0, 4'hF, 32'h80000000, 1'b0, 5);

`ifdef DMEM_MISALIGN_TRAP_EN
      do_access("mis_word", 1'b0, 2'b10, 1'b0, 13'h011, 32'h0, 4'h0, 4'h0, 32'h0, 1'b1, 0);
      do_access("mis_half", 1'b0, 2'b01, 1'b0, 13'h023, 32'h0, 4'h0, 4'h0, 32'h0, 1'b1, 0);
      do_access("mis_st", 1'b1, 2'b10, 1'b0, 13'h012, 32'h55555555, 4'h0, 4'h0, 32'h0, 1'b1, 0);
      check("mis_st_mem", mem[4], 32'h80000000);
`else
      do_access("mis_word", 1'b0, 2'b10, 1'b0, 13'h011, 32'h0, 4'h0, 4'hF, 32'h80000000, 1'b0, 0);
      do_access("mis_half", 1'b0, 2'b01, 1'b0, 13'h023, 32'h0, 4'h0, 4'hC, 32'h00001234, 1'b0, 0);
`endif

      // Reset pulse inside the ACCESS cycle of a store, ahead of the falling edge.
      bus.REQ_VALID = 1'b1;
      bus.REQ_WE    = 1'b1;
      bus.REQ_SIZE  = 2'b10;
      bus.REQ_ADDR  = 13'h040;
      bus.REQ_WDATA = 32'h11111111;
      tick();
      bus.REQ_VALID = 1'b0;
      check("rstacc_we_before", 32'(bus.MEM_WRITE_EN), 32'hF);
      #1 rst_n = 1'b0;
      #1;
      check("rstacc_we_drop", 32'(bus.MEM_WRITE_EN), 32'd0);
      check("rstacc_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("rstacc_req_ready", 32'(bus.REQ_READY), 32'd0);
      #4 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstacc_no_rsp", 32'(bus.RSP_VALID), 32'd0);
      end
      check("rstacc_mem", mem[16], 32'h0);
      check("rstacc_ready", 32'(bus.REQ_READY), 32'd1);
      do_access("ld_w040", 1'b0, 2'b10, 1'b0, 13'h040, 32'h0, 4'h0, 4'hF, 32'h0, 1'b0, 0);

      check("never_both_en", 32'(both_seen), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
